// File: rtl/tile_scan_ctrl_if.sv
// Pixel stream from the tile sequencer to the encoder core (valid/ready with last marker).
interface tile_scan_ctrl_if #(
  parameter int PIX_WIDTH = 8
);
  logic                 pix_valid;
  logic [PIX_WIDTH-1:0] pix_data;
  logic                 pix_last;
  logic                 pix_ready;

  modport master (output pix_valid, pix_data, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_last, output pix_ready);
endinterface

// File: rtl/tile_scan_ctrl.sv
// Encode-side tile sequencer: raster-scans a tile from pixel RAM into the encoder and counts output bytes.
// Optional BYTE_LEN_SAT_EN: byte counter saturates at 511 instead of wrapping.
module tile_scan_ctrl #(
  parameter int PIX_WIDTH  = 8,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [8:0]            tile_width,
  input  logic [8:0]            tile_height,
  input  logic                  en_or_de,
  output logic                  busy,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [PIX_WIDTH-1:0]  ram_rd_data,
  tile_scan_ctrl_if.master      pix,
  input  logic                  enc_byte_valid,
  input  logic                  enc_flush_done,
  output logic                  encode_done,
  output logic [8:0]            byte_len
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, FLUSH, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t state, state_nxt;

  logic [8:0]           w_q, h_q, col_q, row_q;
  logic [8:0]           byte_cnt, byte_cnt_nxt;
  logic                 rd_vld_q, rd_last_q;
  logic [PIX_WIDTH-1:0] mem [2];
  logic [1:0]           last_mem;
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           fifo_cnt;
  logic [2:0]           occ;
  logic                 accept, pop, last_rd, head_last;

  assign accept    = (state == IDLE) && start && en_or_de;
  assign last_rd   = (col_q == w_q - 9'd1) && (row_q == h_q - 9'd1);
  assign head_last = last_mem[rd_ptr];

`ifdef BYTE_LEN_SAT_EN
  assign byte_cnt_nxt = (enc_byte_valid && (byte_cnt != '1)) ? byte_cnt + 9'd1 : byte_cnt;
`else
  assign byte_cnt_nxt = enc_byte_valid ? byte_cnt + 9'd1 : byte_cnt;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept)
               state_nxt = ((tile_width == '0) || (tile_height == '0)) ? DONE : SCAN;
      SCAN:  if (ram_rd_en && last_rd) state_nxt = DRAIN;
      DRAIN: if (pop && head_last)     state_nxt = FLUSH;
      FLUSH: if (enc_flush_done)       state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The pixel being popped this cycle frees its slot, so it counts as credit;
  // without that the 2-entry buffer could not sustain one pixel per cycle.
  always_comb begin
    busy          = (state != IDLE);
    encode_done   = (state == DONE);
    pix.pix_valid = (fifo_cnt != 2'd0);
    pix.pix_data  = mem[rd_ptr];
    pix.pix_last  = (fifo_cnt != 2'd0) && head_last;
    pop           = (fifo_cnt != 2'd0) && pix.pix_ready;
    occ           = {1'b0, fifo_cnt} + {2'b00, rd_vld_q};
    ram_rd_en     = (state == SCAN) && (pop ? (occ < 3'd3) : (occ < 3'd2));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      ram_addr  <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
      last_mem  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= '0;
      byte_cnt  <= '0;
      byte_len  <= '0;
    end else begin
      if (accept) begin
        w_q      <= tile_width;
        h_q      <= tile_height;
        col_q    <= '0;
        row_q    <= '0;
        ram_addr <= '0;
        byte_cnt <= '0;
        byte_len <= '0;
      end

      if (ram_rd_en) begin
        ram_addr <= ram_addr + ADDR_ONE;
        if (col_q == w_q - 9'd1) begin
          col_q <= '0;
          row_q <= row_q + 9'd1;
        end else begin
          col_q <= col_q + 9'd1;
        end
      end

      rd_vld_q  <= ram_rd_en;
      rd_last_q <= ram_rd_en && last_rd;

      if (rd_vld_q) begin
        mem[wr_ptr]      <= ram_rd_data;
        last_mem[wr_ptr] <= rd_last_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_vld_q} - {1'b0, pop};

      if ((state == SCAN) || (state == DRAIN) || (state == FLUSH))
        byte_cnt <= byte_cnt_nxt;
      if ((state == FLUSH) && enc_flush_done)
        byte_len <= byte_cnt_nxt;
    end
  end

endmodule
